clock_ctrl: RTL
===============

Name: clock_ctrl

Overview:
- Controller for the digital-clock time base and display.
- Owns the 1 Hz prescaler that sequences the hours/minutes/seconds counters.
- Provides a RUN / SET_HOUR / SET_MIN mode state machine driven by two pre-debounced button pulses.
- Drives per-field display enables for blinking the field being edited; outputs feed the BCD/7-segment display stage.

Parameters:
- TICK_DIV, 50_000_000, clock cycles per second; must be even and >= 4.
- HALF_DIV, TICK_DIV/2, cycles per blink phase; derived, not overridden.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- mode_btn  in  1  single-cycle pulse; advances mode
- inc_btn  in  1  single-cycle pulse; increments the field being edited
- hours  out  5  0..23, binary
- minutes  out  6  0..59, binary
- seconds  out  6  0..59, binary
- mode  out  2  current state: 0=RUN, 1=SET_HOUR, 2=SET_MIN
- hour_en  out  1  hours display enable (blink)
- min_en  out  1  minutes display enable (blink)
- sec_pulse  out  1  high for exactly one cycle when the seconds value changes due to a tick

Behaviour:
- Reset, sampled on a clock edge, is synchronous and active-high. It sets:
  - hours=0, minutes=0, seconds=0
  - mode=RUN
  - prescaler=0, blink phase=on
  - hour_en=1, min_en=1, sec_pulse=0
- Reset asserted mid-operation (any mode) has the same effect on the next edge. Button pulses during reset are ignored.
- Prescaler counts 0..TICK_DIV-1 in RUN only.
  - On the edge where the count equals TICK_DIV-1: count returns to 0, seconds increments, sec_pulse=1 in the following cycle, coincident with the new seconds value.
  - The first seconds increment is visible TICK_DIV cycles after reset deasserts.
- RUN carry chain:
  - seconds 59 -> 0 with minutes+1.
  - minutes 59 -> 0 with hours+1.
  - hours 23 -> 0.
  - 23:59:59 -> 00:00:00 in one tick.
  - inc_btn is ignored in RUN.
- State transitions on mode_btn: RUN -> SET_HOUR -> SET_MIN -> RUN.
- Entering SET_HOUR:
  - seconds cleared to 0, prescaler cleared, prescaler halted.
  - no ticks and no sec_pulse while in either set mode.
- SET_MIN -> RUN: prescaler restarts from 0, so the next tick comes TICK_DIV cycles after the transition edge.
- In SET_HOUR, inc_btn sets hours = (hours==23) ? 0 : hours+1. No carry; other fields untouched.
- In SET_MIN, inc_btn sets minutes = (minutes==59) ? 0 : minutes+1. No carry into hours.
- mode_btn and inc_btn in the same cycle: mode_btn wins and inc_btn is dropped.
- Increments are visible one cycle after the button pulse.
- Blink:
  - Blink counter runs only in set modes; phase toggles every HALF_DIV cycles.
  - Phase is forced on and the counter cleared on entering any set mode and on every accepted inc_btn.
  - hour_en = phase in SET_HOUR, else 1. min_en = phase in SET_MIN, else 1.
  - In RUN, both enables are 1.
- Mode encoding 3 is unreachable. If ever present, the next edge goes to RUN.

Decomposition:
- Package clock_pkg holds:
  - typedef enum logic [1:0] mode_t {MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN}
  - constants MAX_HOUR=23 and MAX_MIN=59, MAX_SEC=59
  - field width constants HOUR_W=5, MIN_W=6
- One sub-module, tick_gen: a parameterised prescaler with en and sync clr inputs and a single-cycle tick output.
  - Instantiated twice: once for the 1 Hz tick (TICK_DIV), once for the blink phase (HALF_DIV).
- Mode FSM and time counters live in clock_ctrl.

Test Plan (TICK_DIV=10 unless noted):
- Release reset, run 10 cycles -> seconds 0->1 visible at cycle 10; sec_pulse high that cycle only; next change at cycle 20.
- mode_btn, 23 inc_btn, mode_btn, 59 inc_btn, mode_btn, then 600 cycles -> time 23:59:00 before the run, 00:00:00 after the 60th tick with one sec_pulse per tick.
- SET_HOUR, 24 inc_btn pulses -> hours 0 after the 24th; minutes/seconds unchanged; no sec_pulse.
- In SET_HOUR, assert mode_btn and inc_btn same cycle -> mode=SET_MIN, hours unchanged.
- Run 35 cycles to 00:00:03, enter SET_HOUR, assert reset one cycle -> mode=RUN, 00:00:00, both enables 1, next tick 10 cycles after reset release.
- SET_MIN idle -> min_en toggles every 5 cycles and hour_en stays 1; inc_btn mid-off-phase -> min_en=1 next cycle for a full 5 cycles.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types, field widths, limits and a wrap-around increment helper
// for the digital clock controller.
package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
    localparam logic [MIN_W-1:0]  MAX_SEC  = 6'd59;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_t;

    // Increment with wrap to zero once the field limit is reached.
    function automatic logic [MIN_W-1:0] wrap_inc(input logic [MIN_W-1:0] value,
                                                  input logic [MIN_W-1:0] max_val);
        logic [MIN_W-1:0] result;
        if (value == max_val) begin
            result = {MIN_W{1'b0}};
        end else begin
            result = value + 6'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/clock_ctrl_tick_gen.sv
// Parameterised prescaler: counts 0..DIV-1 while enabled and pulses tick
// on the cycle the count wraps. A synchronous clear overrides counting and
// suppresses the tick.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count and wrap detection; clear dominates enable.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = {CNT_W{1'b0}};
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_ctrl.sv
// Digital clock controller: 1 Hz time base, hh:mm:ss counters, RUN /
// SET_HOUR / SET_MIN mode machine and blink enables for the edited field.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mode_btn,
    input  logic              inc_btn,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [MIN_W-1:0]  seconds,
    output logic [1:0]        mode,
    output logic              hour_en,
    output logic              min_en,
    output logic              sec_pulse
);

    localparam int HALF_DIV = TICK_DIV / 2;

    mode_t             mode_q, mode_d;
    logic [HOUR_W-1:0] hours_q, hours_d;
    logic [MIN_W-1:0]  minutes_q, minutes_d;
    logic [MIN_W-1:0]  seconds_q, seconds_d;
    logic              phase_q, phase_d;
    logic              hour_en_q, hour_en_d;
    logic              min_en_q, min_en_d;
    logic              sec_pulse_q, sec_pulse_d;

    logic sec_tick_s, sec_en_s, sec_clr_s;
    logic blink_tick_s, blink_en_s, blink_clr_s;
    logic in_set_s, inc_acc_s, enter_set_s;

    tick_gen #(.DIV(TICK_DIV)) u_sec_tick (
        .clock (clock),
        .reset (reset),
        .en    (sec_en_s),
        .clr   (sec_clr_s),
        .tick  (sec_tick_s)
    );

    tick_gen #(.DIV(HALF_DIV)) u_blink_tick (
        .clock (clock),
        .reset (reset),
        .en    (blink_en_s),
        .clr   (blink_clr_s),
        .tick  (blink_tick_s)
    );

    // Mode sequencing on mode_btn; the unused encoding falls back to RUN.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_RUN:      mode_d = mode_btn ? MODE_SET_HOUR : MODE_RUN;
            MODE_SET_HOUR: mode_d = mode_btn ? MODE_SET_MIN  : MODE_SET_HOUR;
            MODE_SET_MIN:  mode_d = mode_btn ? MODE_RUN      : MODE_SET_MIN;
            default:       mode_d = MODE_RUN;
        endcase
    end

    // Prescaler and blink-counter controls; mode_btn masks inc_btn.
    always_comb begin
        in_set_s    = (mode_q == MODE_SET_HOUR) || (mode_q == MODE_SET_MIN);
        inc_acc_s   = inc_btn && !mode_btn && in_set_s;
        enter_set_s = mode_btn && ((mode_d == MODE_SET_HOUR) || (mode_d == MODE_SET_MIN));
        // Prescaler is held at zero outside RUN so RUN always restarts a full second.
        sec_en_s    = (mode_q == MODE_RUN);
        sec_clr_s   = mode_btn || (mode_q != MODE_RUN);
        blink_en_s  = in_set_s;
        blink_clr_s = enter_set_s || inc_acc_s;
    end

    // Next values for the time fields, blink phase and registered outputs.
    always_comb begin
        hours_d     = hours_q;
        minutes_d   = minutes_q;
        seconds_d   = seconds_q;
        sec_pulse_d = 1'b0;
        case (mode_q)
            MODE_RUN: begin
                if (mode_btn) begin
                    seconds_d = {MIN_W{1'b0}};
                end else if (sec_tick_s) begin
                    sec_pulse_d = 1'b1;
                    seconds_d   = wrap_inc(seconds_q, MAX_SEC);
                    if (seconds_q == MAX_SEC) begin
                        minutes_d = wrap_inc(minutes_q, MAX_MIN);
                        if (minutes_q == MAX_MIN) begin
                            hours_d = HOUR_W'(wrap_inc(MIN_W'(hours_q), MIN_W'(MAX_HOUR)));
                        end else begin
                            hours_d = hours_q;
                        end
                    end else begin
                        minutes_d = minutes_q;
                    end
                end else begin
                    seconds_d = seconds_q;
                end
            end
            MODE_SET_HOUR: begin
                if (inc_acc_s) begin
                    hours_d = HOUR_W'(wrap_inc(MIN_W'(hours_q), MIN_W'(MAX_HOUR)));
                end else begin
                    hours_d = hours_q;
                end
            end
            MODE_SET_MIN: begin
                if (inc_acc_s) begin
                    minutes_d = wrap_inc(minutes_q, MAX_MIN);
                end else begin
                    minutes_d = minutes_q;
                end
            end
            default: begin
                hours_d = hours_q;
            end
        endcase

        if (mode_d == MODE_RUN) begin
            phase_d = 1'b1;
        end else if (blink_clr_s) begin
            phase_d = 1'b1;
        end else if (blink_tick_s) begin
            phase_d = ~phase_q;
        end else begin
            phase_d = phase_q;
        end

        hour_en_d = (mode_d == MODE_SET_HOUR) ? phase_d : 1'b1;
        min_en_d  = (mode_d == MODE_SET_MIN)  ? phase_d : 1'b1;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q      <= MODE_RUN;
            hours_q     <= {HOUR_W{1'b0}};
            minutes_q   <= {MIN_W{1'b0}};
            seconds_q   <= {MIN_W{1'b0}};
            phase_q     <= 1'b1;
            hour_en_q   <= 1'b1;
            min_en_q    <= 1'b1;
            sec_pulse_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            phase_q     <= phase_d;
            hour_en_q   <= hour_en_d;
            min_en_q    <= min_en_d;
            sec_pulse_q <= sec_pulse_d;
        end
    end

    assign hours     = hours_q;
    assign minutes   = minutes_q;
    assign seconds   = seconds_q;
    assign mode      = mode_q;
    assign hour_en   = hour_en_q;
    assign min_en    = min_en_q;
    assign sec_pulse = sec_pulse_q;

endmodule
